// File: rtl/result_writeback_if.sv
// AXI-style write channels (address, data, response) between result_writeback and memory.
// master = write-back engine, slave = memory side.
interface result_writeback_if #(
   parameter int unsigned L      = 8,
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 32
);
   localparam int unsigned BEAT_W = L * WIDTH;

   logic              aw_valid;
   logic              aw_ready;
   logic [ADDR_W-1:0] aw_addr;
   logic [7:0]        aw_len;
   logic              w_valid;
   logic              w_ready;
   logic [BEAT_W-1:0] w_data;
   logic              w_last;
   logic              b_valid;
   logic [1:0]        b_resp;
   logic              b_ready;

   modport master (
      output aw_valid, aw_addr, aw_len, w_valid, w_data, w_last, b_ready,
      input  aw_ready, w_ready, b_valid, b_resp
   );

   modport slave (
      input  aw_valid, aw_addr, aw_len, w_valid, w_data, w_last, b_ready,
      output aw_ready, w_ready, b_valid, b_resp
   );
endinterface

// File: rtl/result_writeback.sv
// Captures the LxL accumulator matrix from the systolic array and writes it out
// as one L-beat burst, row-per-beat or column-per-beat, reporting done/err.
module result_writeback #(
   parameter int unsigned L      = 8,
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      base_addr,
   input  logic                   col_major,
   input  logic                   sum_valid,
   input  logic [L*L*WIDTH-1:0]   sum_in,
   result_writeback_if.master     bus,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);
   localparam int unsigned BEAT_W = L * WIDTH;
   localparam int unsigned MAT_W  = L * L * WIDTH;
   localparam int unsigned CNT_W  = (L > 1) ? $clog2(L) : 1;
   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(L - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_ADDR,
      S_DATA,
      S_RESP
   } state_t;

   state_t            state;
   logic [MAT_W-1:0]  mat_q;
   logic              col_q;
   logic [CNT_W-1:0]  beat_q;
   logic [CNT_W-1:0]  next_k_c;
   logic [BEAT_W-1:0] next_beat_c;

   assign bus.aw_len = 8'(L - 1);

   // Payload of the beat to present next: beat 0 when leaving ADDR, k+1 inside DATA.
   always_comb begin
      next_k_c    = '0;
      next_beat_c = '0;
      if (state == S_DATA && beat_q != LAST_K) begin
         next_k_c = beat_q + CNT_W'(1);
      end
      for (int unsigned j = 0; j < L; j++) begin
         if (col_q) begin
            next_beat_c[j*WIDTH +: WIDTH] = mat_q[(j*L + 32'(next_k_c))*WIDTH +: WIDTH];
         end else begin
            next_beat_c[j*WIDTH +: WIDTH] = mat_q[(32'(next_k_c)*L + j)*WIDTH +: WIDTH];
         end
      end
   end

   // Sequencer with registered channel outputs; valids never retract while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         mat_q        <= '0;
         col_q        <= 1'b0;
         beat_q       <= '0;
         bus.aw_valid <= 1'b0;
         bus.aw_addr  <= '0;
         bus.w_valid  <= 1'b0;
         bus.w_data   <= '0;
         bus.w_last   <= 1'b0;
         bus.b_ready  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  bus.aw_addr <= base_addr;
                  col_q       <= col_major;
                  err         <= 1'b0;
                  busy        <= 1'b1;
                  state       <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (sum_valid) begin
                  mat_q        <= sum_in;
                  bus.aw_valid <= 1'b1;
                  state        <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (bus.aw_ready) begin
                  bus.aw_valid <= 1'b0;
                  bus.w_valid  <= 1'b1;
                  bus.w_data   <= next_beat_c;
                  bus.w_last   <= (LAST_K == '0);
                  beat_q       <= '0;
                  state        <= S_DATA;
               end
            end
            S_DATA: begin
               if (bus.w_ready) begin
                  if (beat_q == LAST_K) begin
                     bus.w_valid <= 1'b0;
                     bus.w_last  <= 1'b0;
                     bus.b_ready <= 1'b1;
                     state       <= S_RESP;
                  end else begin
                     beat_q     <= next_k_c;
                     bus.w_data <= next_beat_c;
                     bus.w_last <= (next_k_c == LAST_K);
                  end
               end
            end
            S_RESP: begin
               if (bus.b_valid) begin
                  bus.b_ready <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  err         <= err | (bus.b_resp != 2'b00);
                  state       <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: expected beats are queued at start and
// popped on each observed data handshake; timing, status and reset are checked inline.
module tb_result_writeback;
   localparam int unsigned L      = 8;
   localparam int unsigned WIDTH  = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned BEAT_W = L * WIDTH;
   localparam int unsigned MAT_W  = L * L * WIDTH;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              col_major;
   logic              sum_valid;
   logic [MAT_W-1:0]  sum_in;
   logic              busy;
   logic              done;
   logic              err;

   logic [MAT_W-1:0]  mat;
   logic [BEAT_W-1:0] exp_q[$];
   int                n_assert = 0;
   int                n_fail   = 0;

   result_writeback_if #(.L(L), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   result_writeback #(.L(L), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .col_major (col_major),
      .sum_valid (sum_valid),
      .sum_in    (sum_in),
      .bus       (bus.master),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [BEAT_W-1:0] obs, input logic [BEAT_W-1:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [MAT_W-1:0] make_mat(input int offset);
      logic [MAT_W-1:0] m;
      m = '0;
      for (int r = 0; r < int'(L); r++)
         for (int c = 0; c < int'(L); c++)
            m[(r*L + c)*WIDTH +: WIDTH] = WIDTH'(r*16 + c + offset);
      return m;
   endfunction

   function automatic logic [BEAT_W-1:0] expect_beat(input logic [MAT_W-1:0] m, input logic cm, input int k);
      logic [BEAT_W-1:0] b;
      int r;
      int c;
      b = '0;
      for (int j = 0; j < int'(L); j++) begin
         r = cm ? j : k;
         c = cm ? k : j;
         b[j*WIDTH +: WIDTH] = m[(r*L + c)*WIDTH +: WIDTH];
      end
      return b;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_aw_valid"}, BEAT_W'(bus.aw_valid), '0);
      check({tag, "_w_valid"},  BEAT_W'(bus.w_valid),  '0);
      check({tag, "_w_last"},   BEAT_W'(bus.w_last),   '0);
      check({tag, "_b_ready"},  BEAT_W'(bus.b_ready),  '0);
      check({tag, "_busy"},     BEAT_W'(busy),         '0);
      check({tag, "_done"},     BEAT_W'(done),         '0);
      check({tag, "_err"},      BEAT_W'(err),          '0);
      check({tag, "_aw_addr"},  BEAT_W'(bus.aw_addr),  '0);
      check({tag, "_w_data"},   bus.w_data,            '0);
      check({tag, "_aw_len"},   BEAT_W'(bus.aw_len),   BEAT_W'(L - 1));
   endtask

   // Runs one burst starting in the current (idle) cycle; returns in the done cycle,
   // or right after reset when abort_beat >= 0.
   task automatic run_burst(input logic cm, input logic [ADDR_W-1:0] addr, input int aw_stall,
                            input int w_mode, input int b_delay, input logic [1:0] resp,
                            input int sv_delay, input bit poke, input int abort_beat);
      int cyc = 0;
      int beats = 0;
      int aw_seen = 0;
      int wp = 0;
      int b_seen = 0;
      int exp_done;
      bit poked = 0;
      bit finished = 0;
      exp_q.delete();
      for (int k = 0; k < int'(L); k++) exp_q.push_back(expect_beat(mat, cm, k));
      exp_done = 12 + sv_delay + aw_stall + (w_mode != 0 ? 2*(int'(L) - 1) : 0) + b_delay;
      start = 1'b1;
      base_addr = addr;
      col_major = cm;
      sum_in = mat;
      sum_valid = 1'b0;
      while (!finished && cyc < 300) begin
         tick();
         cyc++;
         start = 1'b0;
         bus.aw_ready = 1'b0;
         bus.w_ready = 1'b0;
         bus.b_valid = 1'b0;
         bus.b_resp = 2'b00;
         sum_valid = (cyc >= 1 + sv_delay);
         if (cyc == 1) begin
            check("busy_after_start", BEAT_W'(busy), BEAT_W'(1));
            check("err_cleared", BEAT_W'(err), '0);
         end
         if (cyc <= sv_delay + 1) check("aw_before_capture", BEAT_W'(bus.aw_valid), '0);
         if (bus.aw_valid) begin
            check("aw_addr", BEAT_W'(bus.aw_addr), BEAT_W'(addr));
            check("aw_len", BEAT_W'(bus.aw_len), BEAT_W'(L - 1));
            bus.aw_ready = (aw_seen >= aw_stall);
            aw_seen++;
         end
         if (bus.w_valid) begin
            if (abort_beat >= 0 && beats == abort_beat) begin
               rst = 1'b1;
               #1;
               check_all_zero("abort");
               @(negedge clk);
               rst = 1'b0;
               exp_q.delete();
               for (int i = 0; i < 3; i++) begin
                  tick();
                  check("abort_no_valid", BEAT_W'({bus.aw_valid, bus.w_valid, busy}), '0);
               end
               return;
            end
            check("w_data", bus.w_data, exp_q.size() > 0 ? exp_q[0] : '0);
            check("w_last", BEAT_W'(bus.w_last), BEAT_W'(beats == int'(L) - 1));
            bus.w_ready = (w_mode == 0) || (wp % 3 == 0);
            wp++;
            if (bus.w_ready && exp_q.size() > 0) begin
               void'(exp_q.pop_front());
               beats++;
            end
            if (poke && !poked && beats == 2) begin
               start = 1'b1;
               sum_in = ~mat;
               poked = 1;
            end
         end
         if (bus.b_ready) begin
            bus.b_valid = (b_seen >= b_delay);
            bus.b_resp = resp;
            b_seen++;
         end
         if (done) begin
            finished = 1;
            check("done_cycle", BEAT_W'(cyc), BEAT_W'(exp_done));
            check("done_busy", BEAT_W'(busy), '0);
            check("done_err", BEAT_W'(err), BEAT_W'(resp != 2'b00));
            check("beat_count", BEAT_W'(beats), BEAT_W'(L));
         end
      end
      check("done_seen", BEAT_W'(finished), BEAT_W'(1));
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      col_major = 1'b0;
      sum_valid = 1'b0;
      sum_in = '0;
      bus.aw_ready = 1'b0;
      bus.w_ready = 1'b0;
      bus.b_valid = 1'b0;
      bus.b_resp = 2'b00;
      mat = make_mat(0);
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      tick();

      // row-major, then column-major started in the done cycle
      run_burst(1'b0, 32'h0000_1000, 0, 0, 0, 2'b00, 0, 0, -1);
      run_burst(1'b1, 32'h0000_2000, 0, 0, 0, 2'b00, 0, 0, -1);

      // backpressure on all three channels
      run_burst(1'b0, 32'h0000_3000, 3, 1, 5, 2'b00, 0, 0, -1);

      // error response is sticky until the next start
      run_burst(1'b1, 32'h0000_4000, 0, 0, 0, 2'b10, 0, 0, -1);
      tick();
      check("err_held", BEAT_W'(err), BEAT_W'(1));
      check("done_one_pulse", BEAT_W'(done), '0);
      run_burst(1'b0, 32'h0000_5000, 0, 0, 0, 2'b00, 10, 1, -1);
      check("err_after_okay", BEAT_W'(err), '0);

      // start pulsed during DATA must not have queued another burst
      tick();
      check("no_queued_start", BEAT_W'(busy), '0);
      tick();
      check("still_idle", BEAT_W'({busy, bus.aw_valid}), '0);

      // async reset mid-burst, then a clean burst with a new matrix
      mat = make_mat(32'h100);
      run_burst(1'b0, 32'h0000_6000, 0, 0, 0, 2'b00, 0, 0, 4);
      mat = make_mat(32'h200);
      run_burst(1'b1, 32'h0000_7000, 0, 0, 0, 2'b00, 0, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/result_writeback.md
# result_writeback

Downstream stage of the systolic array. After a tile finishes, the tensorcore write-back state pulses `start`. The block then captures the L×L accumulator result matrix from the array in one cycle. It serialises the matrix into L beats of L·WIDTH bits and issues them as a single AXI-style write burst (address, data, response channels). It reports completion and error status back to the tensorcore sequencer.

## Interface
Parameters:
- L, 8, array dimension; the matrix is L×L elements and one burst is L beats.
- WIDTH, 32, bits per result element; one beat is L·WIDTH bits (256 at defaults).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a write-back; honoured only in IDLE.
- base_addr  in  ADDR_W  burst start address; sampled when start is accepted.
- col_major  in  1  output order (0 = row per beat, 1 = column per beat); sampled when start is accepted.
- sum_valid  in  1  array result valid (systolic out_ready).
- sum_in  in  L·L·WIDTH  result matrix; element (r,c) at bits [(r·L+c)·WIDTH +: WIDTH].
- aw_valid  out  1  address request valid.
- aw_ready  in  1  address accepted.
- aw_addr  out  ADDR_W  burst address (= sampled base_addr).
- aw_len  out  8  constant L−1.
- w_valid  out  1  data beat valid.
- w_ready  in  1  data beat accepted.
- w_data  out  L·WIDTH  beat payload.
- w_last  out  1  high on beat L−1 only.
- b_valid  in  1  write response valid.
- b_resp  in  2  write response code (0 = OKAY).
- b_ready  out  1  response accept.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse on burst completion.
- err  out  1  sticky; set when b_resp ≠ 0, cleared on next accepted start.

## Operation
- States: IDLE → CAPTURE → ADDR → DATA → RESP → IDLE.
- IDLE: on start, latch base_addr and col_major, clear err, then go to CAPTURE. sum_valid is ignored in IDLE.
- CAPTURE: wait for sum_valid. On sum_valid, latch sum_in into the internal L·L·WIDTH buffer and go to ADDR.
- ADDR: aw_valid = 1. On aw_valid && aw_ready, go to DATA with beat counter k = 0.
- DATA: w_valid = 1.
  - col_major = 0: lane j of beat k is element (k, j).
  - col_major = 1: lane j of beat k is element (j, k).
  - Lane j occupies w_data[j·WIDTH +: WIDTH].
  - On a handshake, k increments. The handshake on k = L−1 (with w_last = 1) moves to RESP.
- RESP: b_ready = 1. On b_valid, set err if b_resp ≠ 0, pulse done next cycle, and return to IDLE.
- start is ignored in every state other than IDLE; it is not queued.
- aw_valid, w_valid, aw_addr, w_data and w_last hold stable while valid is high and ready is low (no retraction).
- The buffer is frozen after capture, so changes on sum_in during ADDR, DATA or RESP have no effect.
- The beat counter has no wrap: it is bounded by L and reset to 0 on entry to DATA.

## Timing
- Reset (async, any state): state = IDLE and buffer = 0. All outputs are 0: aw_valid, w_valid, w_last, b_ready, busy, done, err, aw_addr, w_data. aw_len always reads L−1.
- Reset mid-burst abandons the transaction; no further valid is asserted.
- Minimum latency, with sum_valid and all readys tied high and start at cycle 0:
  - CAPTURE at cycle 1 (capture);
  - aw_valid at cycle 2;
  - w_valid at cycles 3..3+L−1 (3..10);
  - b_ready at cycle 11;
  - done at cycle 12 if b_valid is high at 11.
- Each cycle that ready is low during ADDR or DATA adds exactly one cycle. w_ready low on beat k repeats beat k unchanged.
- done and IDLE coincide. start in that same cycle is accepted (back-to-back tiles).
- busy rises the cycle after start and falls in the cycle done is asserted.

## Test plan
- Basic row-major: element (r,c) = r·16+c, base_addr = 0x1000, all readys high → aw_addr = 0x1000, aw_len = 7; beat k lane j = 16k+j; w_last only on beat 7; done at cycle 12; err = 0.
- Column-major: same matrix, col_major = 1 → beat k lane j = 16j+k; beat 7 is {0x77, 0x67, …, 0x07}.
- Backpressure: aw_ready low for 3 cycles; w_ready toggling 1,0,0,1…; b_valid delayed 5 cycles → payload and valid stable during stalls, 8 beats exactly, done delayed by the total stall count.
- Error response: b_resp = 2 → err = 1 after done and held. Next start clears err; the next OKAY burst leaves err = 0.
- Ignored start / capture wait: pulse start during DATA → no effect. Hold sum_valid low for 10 cycles in CAPTURE → aw_valid stays 0 until capture. Change sum_in during DATA → output unchanged.
- Async reset at beat 4 → all outputs 0 immediately, busy = 0. A new start completes a full, correct 8-beat burst.
